// File: rtl/alu_preprocess_fifo.sv
// Operand preprocessor for an adder datapath: decodes A/B/Op into adder operands
// at capture time and buffers the results in a small valid/ready FIFO.
module alu_preprocess_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  input  logic [2:0]               Op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         AMod,
  output logic [WIDTH-1:0]         BMod,
  output logic [2:0]               OpOut,
  output logic                     cpl_flag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] amod;
    logic [WIDTH-1:0] bmod;
    logic [2:0]       op;
    logic             cpl;
  } entry_t;

  // Op[2] set is a plain pass-through; the low codes build increment/subtract forms.
  function automatic entry_t decode_op(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input logic [2:0]       op);
    entry_t e;
    e.op = op;
    if (op[2]) begin
      e.amod = a;
      e.bmod = b;
      e.cpl  = 1'b0;
    end else begin
      case (op[1:0])
        2'b01: begin
          e.amod = WIDTH'(1'b1);
          e.bmod = a;
          e.cpl  = 1'b0;
        end
        2'b10: begin
          e.amod = WIDTH'(1'b1);
          e.bmod = ~a;
          e.cpl  = 1'b1;
        end
        2'b11: begin
          e.amod = WIDTH'(1'b1);
          e.bmod = ~b;
          e.cpl  = 1'b1;
        end
        default: begin
          e.amod = a;
          e.bmod = b;
          e.cpl  = 1'b0;
        end
      endcase
    end
    return e;
  endfunction

  entry_t           mem_r [DEPTH];
  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;
  logic             in_ready_s;
  logic             out_valid_s;
  entry_t           head_s;

  // in_ready depends only on registered occupancy, so out_ready never reaches it.
  assign in_ready_s  = (count_r < CW'(DEPTH));
  assign out_valid_s = (count_r != CW'(0));
  assign push_s      = in_valid & in_ready_s;
  assign pop_s       = out_valid_s & out_ready;

  // Entry storage: written at the tail on an accepted push, never cleared.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_r[tail_r] <= decode_op(A, B, Op);
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r  <= AW'(0);
      tail_r  <= AW'(0);
      count_r <= CW'(0);
    end else begin
      if (push_s) begin
        tail_r <= tail_r + AW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry view; forced to zero while empty so stale storage never leaks out.
  always_comb begin
    head_s = '0;
    if (out_valid_s) begin
      head_s = mem_r[head_r];
    end else begin
      head_s = '0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign AMod      = head_s.amod;
  assign BMod      = head_s.bmod;
  assign OpOut     = head_s.op;
  assign cpl_flag  = head_s.cpl;
  assign count     = count_r;

endmodule

// File: tb/tb_alu_preprocess_fifo.sv
// Randomized and directed bench for alu_preprocess_fifo; two instances
// (4-bit/2-deep and 8-bit/4-deep) are compared each cycle against queue models.
module tb_alu_preprocess_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // instance 0: WIDTH=4, DEPTH=2
  logic       in_valid0_s, in_ready0_s, out_valid0_s, out_ready0_s, cpl0_s;
  logic [3:0] a0_s, b0_s, amod0_s, bmod0_s;
  logic [2:0] op0_s, opout0_s;
  logic [1:0] count0_s;

  // instance 1: WIDTH=8, DEPTH=4
  logic       in_valid1_s, in_ready1_s, out_valid1_s, out_ready1_s, cpl1_s;
  logic [7:0] a1_s, b1_s, amod1_s, bmod1_s;
  logic [2:0] op1_s, opout1_s;
  logic [2:0] count1_s;

  alu_preprocess_fifo #(.WIDTH(4), .DEPTH(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0_s), .in_ready(in_ready0_s),
    .A(a0_s), .B(b0_s), .Op(op0_s), .out_valid(out_valid0_s), .out_ready(out_ready0_s),
    .AMod(amod0_s), .BMod(bmod0_s), .OpOut(opout0_s), .cpl_flag(cpl0_s), .count(count0_s)
  );

  alu_preprocess_fifo #(.WIDTH(8), .DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1_s), .in_ready(in_ready1_s),
    .A(a1_s), .B(b1_s), .Op(op1_s), .out_valid(out_valid1_s), .out_ready(out_ready1_s),
    .AMod(amod1_s), .BMod(bmod1_s), .OpOut(opout1_s), .cpl_flag(cpl1_s), .count(count1_s)
  );

  typedef struct packed {
    logic [7:0] amod;
    logic [7:0] bmod;
    logic [2:0] op;
    logic       cpl;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Adder operand rules written arithmetically: complement of x in w bits is (2^w-1)-x.
  function automatic ent_t ref_decode(input int w, input logic [7:0] a_v,
                                      input logic [7:0] b_v, input logic [2:0] op_v);
    ent_t       e;
    logic [7:0] mask;
    mask  = 8'((1 << w) - 1);
    e.op  = op_v;
    case (op_v)
      3'd1:    begin e.amod = 8'd1; e.bmod = a_v;        e.cpl = 1'b0; end
      3'd2:    begin e.amod = 8'd1; e.bmod = mask - a_v; e.cpl = 1'b1; end
      3'd3:    begin e.amod = 8'd1; e.bmod = mask - b_v; e.cpl = 1'b1; end
      default: begin e.amod = a_v;  e.bmod = b_v;        e.cpl = 1'b0; end
    endcase
    return e;
  endfunction

  // One clock: compare both instances mid-cycle, then advance the models at the edge.
  task automatic cycle();
    ent_t h0, h1, e0, e1;
    bit   push0, pop0, push1, pop1;
    @(negedge clk);
    h0 = (q0.size() != 0) ? q0[0] : '0;
    h1 = (q1.size() != 0) ? q1[0] : '0;
    check("count0",     count0_s,     q0.size());
    check("in_ready0",  in_ready0_s,  q0.size() < 2);
    check("out_valid0", out_valid0_s, q0.size() != 0);
    check("amod0",      amod0_s,      h0.amod);
    check("bmod0",      bmod0_s,      h0.bmod);
    check("opout0",     opout0_s,     h0.op);
    check("cpl0",       cpl0_s,       h0.cpl);
    check("count1",     count1_s,     q1.size());
    check("in_ready1",  in_ready1_s,  q1.size() < 4);
    check("out_valid1", out_valid1_s, q1.size() != 0);
    check("amod1",      amod1_s,      h1.amod);
    check("bmod1",      bmod1_s,      h1.bmod);
    check("opout1",     opout1_s,     h1.op);
    check("cpl1",       cpl1_s,       h1.cpl);
    push0 = in_valid0_s && (q0.size() < 2);
    pop0  = out_ready0_s && (q0.size() != 0);
    push1 = in_valid1_s && (q1.size() < 4);
    pop1  = out_ready1_s && (q1.size() != 0);
    e0 = ref_decode(4, {4'b0000, a0_s}, {4'b0000, b0_s}, op0_s);
    e1 = ref_decode(8, a1_s, b1_s, op1_s);
    @(posedge clk);
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (pop0)  void'(q0.pop_front());
      if (push0) q0.push_back(e0);
      if (pop1)  void'(q1.pop_front());
      if (push1) q1.push_back(e1);
    end
    #1;
  endtask

  // Offer one operand set to instance 0 and hold it until accepted or the budget expires.
  task automatic push0(input logic [3:0] a_v, input logic [3:0] b_v, input logic [2:0] op_v);
    bit acc;
    acc = 1'b0;
    in_valid0_s = 1'b1; a0_s = a_v; b0_s = b_v; op0_s = op_v;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready0_s;
      cycle();
    end
    if (!acc) check("push0_timeout", 32'd0, 32'd1);
    in_valid0_s = 1'b0;
  endtask

  initial begin
    bit pend0, pend1;
    rst_n = 1'b0;
    in_valid0_s = 1'b0; out_ready0_s = 1'b0; a0_s = 4'h0; b0_s = 4'h0; op0_s = 3'd0;
    in_valid1_s = 1'b0; out_ready1_s = 1'b0; a1_s = 8'h0; b1_s = 8'h0; op1_s = 3'd0;
    #1;

    // reset held two cycles, then released
    cycle(); cycle();
    rst_n = 1'b1;
    check("rst_out_valid", out_valid0_s, 1'b0);
    check("rst_in_ready",  in_ready0_s,  1'b1);
    check("rst_count",     count0_s,     2'd0);
    check("rst_amod",      amod0_s,      4'b0000);
    check("rst_bmod",      bmod0_s,      4'b0000);
    cycle();

    // decode cases
    push0(4'b0011, 4'b0000, 3'b010);
    check("dec010_amod", amod0_s, 4'b0001);
    check("dec010_bmod", bmod0_s, 4'b1100);
    check("dec010_cpl",  cpl0_s,  1'b1);
    check("dec010_op",   opout0_s, 3'b010);
    out_ready0_s = 1'b1; cycle(); out_ready0_s = 1'b0;
    push0(4'b0000, 4'b0110, 3'b011);
    check("dec011_amod", amod0_s, 4'b0001);
    check("dec011_bmod", bmod0_s, 4'b1001);
    out_ready0_s = 1'b1; cycle(); out_ready0_s = 1'b0;
    push0(4'b1010, 4'b0101, 3'b101);
    check("dec101_amod", amod0_s, 4'b1010);
    check("dec101_bmod", bmod0_s, 4'b0101);
    check("dec101_cpl",  cpl0_s,  1'b0);
    out_ready0_s = 1'b1; cycle(); out_ready0_s = 1'b0;

    // full: two accepted, third held until space
    push0(4'h1, 4'h0, 3'b000);
    push0(4'h2, 4'h0, 3'b000);
    check("full_count",    count0_s,    2'd2);
    check("full_in_ready", in_ready0_s, 1'b0);
    in_valid0_s = 1'b1; a0_s = 4'h3; b0_s = 4'h0; op0_s = 3'b000;
    cycle(); cycle();
    check("full_held_count", count0_s, 2'd2);
    check("full_head",       amod0_s,  4'h1);
    out_ready0_s = 1'b1;
    push0(4'h3, 4'h0, 3'b000);
    for (int i = 0; i < 4; i++) cycle();
    check("full_drained", out_valid0_s, 1'b0);
    out_ready0_s = 1'b0;

    // concurrent push/pop at count=1
    push0(4'h9, 4'h4, 3'b100);
    out_ready0_s = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid0_s = 1'b1; a0_s = 4'(i + 5); b0_s = 4'(i); op0_s = 3'(i);
      cycle();
      check("conc_count", count0_s, 2'd1);
    end
    in_valid0_s = 1'b0;
    cycle();
    out_ready0_s = 1'b0;

    // reset while full flushes; request during reset discarded
    push0(4'h7, 4'h1, 3'b000);
    push0(4'h8, 4'h2, 3'b000);
    rst_n = 1'b0; in_valid0_s = 1'b1; out_ready0_s = 1'b1; a0_s = 4'hE;
    cycle();
    rst_n = 1'b1; in_valid0_s = 1'b0; out_ready0_s = 1'b0;
    check("flush_out_valid", out_valid0_s, 1'b0);
    check("flush_count",     count0_s,     2'd0);
    check("flush_in_ready",  in_ready0_s,  1'b1);
    push0(4'h5, 4'h6, 3'b000);
    check("flush_alone_count", count0_s, 2'd1);
    check("flush_alone_amod",  amod0_s,  4'h5);
    out_ready0_s = 1'b1; cycle(); out_ready0_s = 1'b0;

    // wide/deep instance
    in_valid1_s = 1'b1; a1_s = 8'h7F; b1_s = 8'h00; op1_s = 3'b001;
    cycle();
    check("w8_amod", amod1_s, 8'h01);
    check("w8_bmod", bmod1_s, 8'h7F);
    for (int i = 0; i < 3; i++) begin
      a1_s = 8'($urandom); b1_s = 8'($urandom); op1_s = 3'($urandom);
      cycle();
    end
    in_valid1_s = 1'b0;
    check("w8_count",    count1_s,    3'd4);
    check("w8_in_ready", in_ready1_s, 1'b0);
    out_ready1_s = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    out_ready1_s = 1'b0;

    // random traffic with producer hold and occasional reset
    pend0 = 1'b0; pend1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bit acc0, acc1;
      if (!pend0) begin
        in_valid0_s = ($urandom_range(0, 9) < 7);
        a0_s = 4'($urandom); b0_s = 4'($urandom); op0_s = 3'($urandom);
      end
      if (!pend1) begin
        in_valid1_s = ($urandom_range(0, 9) < 6);
        a1_s = 8'($urandom); b1_s = 8'($urandom); op1_s = 3'($urandom);
      end
      out_ready0_s = ($urandom_range(0, 9) < 5);
      out_ready1_s = ($urandom_range(0, 9) < 4);
      rst_n = ($urandom_range(0, 59) != 0);
      acc0 = in_ready0_s || !rst_n;
      acc1 = in_ready1_s || !rst_n;
      cycle();
      pend0 = in_valid0_s && !acc0;
      pend1 = in_valid1_s && !acc1;
    end
    rst_n = 1'b1;
    in_valid0_s = 1'b0; in_valid1_s = 1'b0;
    out_ready0_s = 1'b1; out_ready1_s = 1'b1;
    for (int i = 0; i < 5; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
